imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Loads a program image from the UART byte stream into the instruction memory and holds the pipeline while it does so. It sits between the UART receiver and the write port of the instruction memory. The CPU is held via `cpu_hold`, which drives the IF/ID stall and reset logic. A framed protocol carries the image: length, big-endian words, then a checksum. An idle timeout aborts partial transfers.

## Interface
- `ROM_SIZE`, 1024, instruction memory depth in words
- `ROM_SIZE_BIT`, 10, word-address width
- `TIMEOUT_CYCLES`, 1000000, idle cycles allowed between bytes once a load has started
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `boot_req`  in  1  level/pulse; starts a load from IDLE or ERR
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid
- `rx_data`  in  8  received byte
- `mem_we`  out  1  instruction memory write enable
- `mem_addr`  out  32  byte address, word aligned (`[1:0]`=0)
- `mem_wdata`  out  32  word to write
- `cpu_hold`  out  1  high whenever not IDLE
- `done`  out  1  one-cycle pulse on successful load
- `err`  out  1  sticky error flag

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
- IDLE:
  - `rx_valid` is ignored.
  - `boot_req` moves to LEN_HI and clears the word count, byte index, checksum and `err`.
- LEN_HI / LEN_LO: each accepted byte forms the 16-bit count N (high byte first).
- After LEN_LO:
  - N > ROM_SIZE → ERR.
  - N = 0 → CSUM.
  - Otherwise → DATA.
- DATA:
  - Bytes assemble a word MSB-first.
  - Each data byte is added into an 8-bit running sum (mod 256).
  - When the 4th byte of word k is accepted, the next cycle has `mem_we`=1, `mem_addr`=k<<2 and `mem_wdata`=the word.
  - After word N-1 is written → CSUM.
- CSUM:
  - Received byte equals the sum → DONE.
  - Otherwise → ERR. Words already written stay in memory.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- ERR:
  - `err`=1 and `cpu_hold`=1 stay asserted.
  - `boot_req` restarts at LEN_HI; `rx_valid` is ignored.
- Timeout:
  - Applies in LEN_HI, LEN_LO, DATA and CSUM.
  - The counter resets on every accepted byte and on state entry.
  - Reaching TIMEOUT_CYCLES-1 → ERR.
  - If `rx_valid` arrives in the same cycle as expiry, the byte wins and the counter resets.
- `boot_req` while in LEN_HI..DONE is ignored.

## Timing
- Reset values:
  - state IDLE.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_hold`=0, `done`=0, `err`=0.
  - Counters and checksum are 0.
- `cpu_hold` is registered. It rises the cycle after `boot_req` is accepted and falls the cycle after `done`.
- Write latency: `mem_we` is asserted 1 cycle after the 4th byte's `rx_valid`. It is never asserted for two consecutive cycles, because `rx_valid` strobes are at least 2 cycles apart by UART construction.
- Only one byte is consumed per `rx_valid` strobe; no back-pressure.
- `reset` mid-load returns to IDLE immediately:
  - `cpu_hold` drops the next cycle.
  - Partial memory contents are left as written.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - the state encoding constants;
  - the protocol constants: header length 2 bytes, word size 4 bytes, checksum width 8;
  - `TIMEOUT_CYCLES` default.
- One natural sub-module: `byte_word_packer`. It shifts in bytes MSB-first and flags word completion on the 4th byte. It is cleared on state entry to DATA.
- The FSM, timeout counter and checksum stay in `imem_boot_loader`.

## Test plan
- Load N=2, words 0x20080005, 0x00000000, checksum 0x2D:
  - 2 writes at addr 0x0 then 0x4 with those data;
  - `done` pulses once;
  - `cpu_hold` high from cycle after `boot_req` to cycle after `done`;
  - `err`=0.
- N=0, checksum 0x00 → no `mem_we`, `done` pulses, return to IDLE.
- N=1025 → ERR right after LEN_LO, no writes, `err`=1, `cpu_hold`=1.
- Same image as case 1 with checksum 0x2E → both words written, then `err`=1, no `done`.
- Stop sending after 5 bytes with TIMEOUT_CYCLES=16 → ERR exactly 16 cycles after the last byte. A following `boot_req` plus a valid image succeeds and clears `err`.
- `reset` asserted during DATA → all outputs at reset values next cycle. `rx_valid` bytes afterwards with no `boot_req` produce no writes.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// Protocol: 2 header bytes (word count), 4 bytes per word, 8-bit checksum.
package imem_boot_loader_pkg;

    localparam int HDR_BYTES       = 2;
    localparam int WORD_BYTES      = 4;
    localparam int CSUM_W          = 8;
    localparam int TIMEOUT_DEFAULT = 1000000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Shifts received bytes into a word MSB-first; flags the byte that completes it.
// Ports: clk, reset, clear_i, byte_valid_i, byte_i -> word_o, word_done_o.
module byte_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    output logic [WORD_BYTES*8-1:0] word_o,
    output logic                    word_done_o
);

    localparam int WW = WORD_BYTES * 8;
    localparam int IW = $clog2(WORD_BYTES);

    logic [WW-9:0] shift_q;
    logic [IW-1:0] idx_q;

    // The completed word includes the byte arriving this cycle.
    assign word_o      = {shift_q, byte_i};
    assign word_done_o = byte_valid_i && (idx_q == IW'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (byte_valid_i) begin
            shift_q <= word_o[WW-9:0];
            idx_q   <= word_done_o ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed UART image (count, big-endian words, checksum) into IMEM and holds the CPU.
// Ports: clk, reset, boot_req, rx_valid, rx_data -> mem_we, mem_addr, mem_wdata, cpu_hold, done, err.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ROM_SIZE       = 1024,
    parameter int ROM_SIZE_BIT   = 10,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        boot_req,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int HW = HDR_BYTES * 8;

    state_t            state_q, state_d;
    logic [HW-1:0]     len_q, len_d;
    logic [15:0]       word_q, word_d;
    logic [CSUM_W-1:0] sum_q, sum_d;
    logic [31:0]       tmo_q, tmo_d;
    logic [HW-1:0]     len_nx;
    logic              active;

    logic        mem_we_q, cpu_hold_q, done_q, err_q;
    logic [31:0] mem_addr_q, mem_wdata_q;

    logic        pk_valid, pk_clear, pk_done;
    logic [31:0] pk_word;

    assign pk_valid = rx_valid && (state_q == S_DATA);
    assign pk_clear = (state_d == S_DATA) && (state_q != S_DATA);
    assign len_nx   = {len_q[HW-9:0], rx_data};

    byte_word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (pk_clear),
        .byte_valid_i(pk_valid),
        .byte_i      (rx_data),
        .word_o      (pk_word),
        .word_done_o (pk_done)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        word_d  = word_q;
        sum_d   = sum_q;
        tmo_d   = tmo_q + 32'd1;
        active  = 1'b0;
        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (boot_req) begin
                    state_d = S_LEN_HI;
                    len_d   = '0;
                    word_d  = '0;
                    sum_d   = '0;
                end
            end
            S_LEN_HI: begin
                active = 1'b1;
                if (rx_valid) begin
                    len_d   = len_nx;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                active = 1'b1;
                if (rx_valid) begin
                    len_d = len_nx;
                    if (len_nx > HW'(ROM_SIZE))
                        state_d = S_ERR;
                    else if (len_nx == '0)
                        state_d = S_CSUM;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                active = 1'b1;
                if (rx_valid) begin
                    sum_d = sum_q + rx_data;
                end
                if (pk_done) begin
                    word_d = word_q + 16'd1;
                    if (word_q + 16'd1 == len_q)
                        state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                active = 1'b1;
                if (rx_valid)
                    state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (active && !rx_valid && tmo_q == 32'(TIMEOUT_CYCLES - 1))
            state_d = S_ERR;
        if (!active || rx_valid || state_d != state_q)
            tmo_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_q      <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            word_q   <= word_d;
            sum_q    <= sum_d;
            tmo_q    <= tmo_d;
            mem_we_q <= pk_done;
            if (pk_done) begin
                mem_addr_q  <= {{(30 - ROM_SIZE_BIT){1'b0}},
                                word_q[ROM_SIZE_BIT-1:0], 2'b00};
                mem_wdata_q <= pk_word;
            end
            cpu_hold_q <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERR);
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed protocol cases plus random images.
// Expected writes/done/err come from a byte-stream model of the framing protocol.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset, boot_req, rx_valid;
    logic [7:0]  rx_data;
    logic        mem_we, cpu_hold, done, err;
    logic [31:0] mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;

    logic [63:0] wq[$];
    int          done_cnt = 0;
    logic        hold_after_done = 1'b0;
    logic        done_prev = 1'b0;
    bit          in_err = 1'b0;

    always #5 clk = ~clk;

    imem_boot_loader #(
        .ROM_SIZE      (1024),
        .ROM_SIZE_BIT  (10),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .boot_req (boot_req),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always @(negedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
        if (done) done_cnt++;
        if (done_prev) hold_after_done = cpu_hold;
        done_prev = done;
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] b, int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        cyc(1);
        rx_valid = 1'b0;
        cyc(gap);
    endtask

    task automatic pulse_boot();
        boot_req = 1'b1;
        cyc(1);
        boot_req = 1'b0;
    endtask

    // Model: frame = N (big endian), words MSB-first, sum of data bytes mod 256.
    task automatic run_load(input logic [31:0] words[$], input int n,
                            input bit bad_csum, input int gap_max);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        logic [7:0] cs;
        logic [7:0] by;
        int         wbase, dbase, nw;
        bit         ok;
        sum = 8'h00;
        bytes.push_back(n[15:8]);
        bytes.push_back(n[7:0]);
        if (n <= 1024) begin
            foreach (words[i]) begin
                for (int b = 3; b >= 0; b--) begin
                    by = words[i][8*b +: 8];
                    bytes.push_back(by);
                    sum = sum + by;
                end
            end
            cs = bad_csum ? sum + 8'd1 : sum;
            bytes.push_back(cs);
        end
        ok = (n <= 1024) && !bad_csum;
        nw = (n <= 1024) ? n : 0;
        wbase = wq.size();
        dbase = done_cnt;
        chk("hold_before", {63'b0, cpu_hold}, {63'b0, in_err});
        pulse_boot();
        chk("hold_rise", {63'b0, cpu_hold}, 64'd1);
        chk("err_clear", {63'b0, err}, 64'd0);
        foreach (bytes[i]) begin
            rx_valid = 1'b1;
            rx_data  = bytes[i];
            cyc(1);
            rx_valid = 1'b0;
            if (i == 1 && n > 1024)
                chk("err_after_len", {63'b0, err}, 64'd1);
            cyc($urandom_range(gap_max, 1));
        end
        cyc(3);
        chk("nwrites", 64'(wq.size() - wbase), 64'(nw));
        for (int i = 0; i < nw && i < wq.size() - wbase; i++)
            chk("write", wq[wbase + i], {32'(i * 4), words[i]});
        chk("done_cnt", 64'(done_cnt - dbase), {63'b0, ok});
        chk("err_end", {63'b0, err}, {63'b0, !ok});
        chk("hold_end", {63'b0, cpu_hold}, {63'b0, !ok});
        if (ok) chk("hold_after_done", {63'b0, hold_after_done}, 64'd0);
        in_err = !ok;
    endtask

    initial begin
        logic [31:0] img[$];
        logic [31:0] none[$];
        int          wbase;
        int          nrand;

        reset    = 1'b1;
        boot_req = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cyc(3);
        chk("rst_we", {63'b0, mem_we}, 64'd0);
        chk("rst_addr", {32'b0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'b0, mem_wdata}, 64'd0);
        chk("rst_hold", {63'b0, cpu_hold}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_err", {63'b0, err}, 64'd0);
        reset = 1'b0;
        cyc(2);

        // Reference image, checksum 0x2D
        img = '{32'h20080005, 32'h00000000};
        run_load(img, 2, 1'b0, 4);
        // Empty image
        run_load(none, 0, 1'b0, 3);
        // Oversized count
        run_load(none, 1025, 1'b0, 3);
        // Reference image with wrong checksum (0x2E), started from ERR
        run_load(img, 2, 1'b1, 4);

        // Idle timeout after 5 bytes
        wbase = wq.size();
        pulse_boot();
        send(8'h00, 2);
        send(8'h02, 2);
        send(8'h11, 2);
        send(8'h22, 2);
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        cyc(1);
        rx_valid = 1'b0;
        cyc(15);
        chk("tmo_early", {63'b0, err}, 64'd0);
        cyc(1);
        chk("tmo_err", {63'b0, err}, 64'd1);
        chk("tmo_hold", {63'b0, cpu_hold}, 64'd1);
        chk("tmo_nowr", 64'(wq.size() - wbase), 64'd0);
        in_err = 1'b1;
        img = '{$urandom(), $urandom(), $urandom()};
        run_load(img, 3, 1'b0, 5);

        // Reset in the middle of DATA
        pulse_boot();
        send(8'h00, 2);
        send(8'h03, 2);
        for (int i = 0; i < 6; i++) send(8'(i + 1), 2);
        reset = 1'b1;
        cyc(1);
        chk("mid_we", {63'b0, mem_we}, 64'd0);
        chk("mid_addr", {32'b0, mem_addr}, 64'd0);
        chk("mid_wdata", {32'b0, mem_wdata}, 64'd0);
        chk("mid_hold", {63'b0, cpu_hold}, 64'd0);
        chk("mid_done", {63'b0, done}, 64'd0);
        chk("mid_err", {63'b0, err}, 64'd0);
        reset = 1'b0;
        cyc(1);
        wbase = wq.size();
        for (int i = 0; i < 8; i++) send(8'($urandom()), 2);
        cyc(3);
        chk("post_rst_nowr", 64'(wq.size() - wbase), 64'd0);
        chk("post_rst_hold", {63'b0, cpu_hold}, 64'd0);
        in_err = 1'b0;

        // Random images, some with corrupted checksum
        for (int t = 0; t < 6; t++) begin
            img = {};
            nrand = $urandom_range(6, 1);
            for (int i = 0; i < nrand; i++) img.push_back($urandom());
            run_load(img, nrand, 1'($urandom_range(1, 0)), 5);
        end

        // Largest legal image
        img = {};
        for (int i = 0; i < 1024; i++) img.push_back($urandom());
        run_load(img, 1024, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
